seg_signed_display: RTL and testbench

Parametrised signed-number display driver for the board's multiplexed 7-segment display. It converts an NBITS signed input, in two's complement or sign-magnitude, to NDIGITS decimal digits using a sequential shift-add-3 (double-dabble) converter with a load/busy/done handshake. It holds the converted result and time-multiplexes it across the digit positions, with leading-zero blanking, a minus sign and overflow indication. It sits between the switch/ALU datapath (sum and product results) and the SEG outputs of top.

---
 rtl/seg_signed_display_pkg.sv | 46 ++++
 rtl/bin2bcd_seq.sv | 114 +++++++++++
 rtl/seg_signed_display.sv | 157 +++++++++++++++
 tb/tb_seg_signed_display.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_signed_display_pkg.sv
// Shared types, constants and helpers for the signed 7-segment display driver.
//   conv_state_e : state of the sequential binary-to-BCD converter
//   SEG_BLANK    : segment pattern for a blanked digit
//   SEG_DASH     : segment pattern shown on every digit when out of range
//   seg_encode() : BCD nibble -> segments a..g (bit 0 = a), active-high
//   max_dec()    : largest decimal value that fits in a given digit count
package seg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConvert,
    StDone
  } conv_state_e;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DASH  = 8'h40;

  // Nibbles 10..15 cannot come out of the converter for in-range values; show nothing.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  function automatic int unsigned max_dec(input int unsigned ndigits);
    int unsigned pow;
    pow = 1;
    for (int unsigned i = 0; i < ndigits; i++) begin
      pow = pow * 10;
    end
    return pow - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 (double-dabble) binary-to-BCD converter.
//   clk_2, reset : clock (rising edge), asynchronous active-high reset
//   load         : start a conversion of mag; honoured only while idle
//   mag          : unsigned magnitude to convert, sampled on an accepted load
//   busy         : registered, high from the accepting edge until the result is out
//   done         : registered one-cycle pulse while in the DONE state
//   last         : high in the cycle whose clock edge performs the final shift
//   bcd          : accumulator value after this cycle's adjust+shift; on the cycle
//                  where last is high it is the finished result
// Digits that do not fit in NDIGITS are shifted out of the top and lost.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int unsigned NBITS   = 8,
  parameter int unsigned NDIGITS = 3
) (
  input  logic                   clk_2,
  input  logic                   reset,
  input  logic                   load,
  input  logic [NBITS-1:0]       mag,
  output logic                   busy,
  output logic                   done,
  output logic                   last,
  output logic [4*NDIGITS-1:0]   bcd
);

  localparam int unsigned BW = 4 * NDIGITS;
  localparam int unsigned CW = (NBITS > 1) ? $clog2(NBITS) : 1;

  conv_state_e     state_q, state_d;
  logic [BW-1:0]    acc_q, acc_d;
  logic [NBITS-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    shifted;
  logic             last_shift;

  // Add-3 correction on every nibble >= 5, then shift the next binary bit in.
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < int'(NDIGITS); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = (adj << 1) | BW'(sh_q[NBITS-1]);
  end

  assign last_shift = (state_q == StConvert) && (cnt_q == CW'(NBITS - 1));

  // State register and datapath registers.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      acc_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          state_d = StConvert;
          acc_d   = '0;
          sh_d    = mag;
          cnt_d   = '0;
        end
      end
      StConvert: begin
        acc_d = shifted;
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (last_shift) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs: busy/done are registered copies of the upcoming state.
  always_comb begin
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
    busy   = busy_q;
    done   = done_q;
    last   = last_shift;
    bcd    = shifted;
  end

endmodule

// File: rtl/seg_signed_display.sv
// Signed-number driver for a multiplexed 7-segment display.
//   clk_2, reset : clock (rising edge), asynchronous active-high reset
//   value, mode  : number to show (mode 0 two's complement, 1 sign-magnitude),
//                  sampled when a load is accepted
//   load         : conversion request, accepted only while not busy
//   busy, done   : conversion in progress / one-cycle pulse on a new displayed result
//   overflow     : displayed magnitude does not fit in NDIGITS decimal digits
//   bcd          : displayed magnitude in BCD, digit 0 in the LSBs
//   dig_sel      : one-hot active-high digit select, advanced every REFRESH_DIV cycles
//   SEG          : segments a..g on bits 0..6, minus sign on bit 7
// The previous result stays on the display until the new one is complete.
module seg_signed_display
  import seg_pkg::*;
#(
  parameter int unsigned NBITS       = 8,
  parameter int unsigned NDIGITS     = 3,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                 clk_2,
  input  logic                 reset,
  input  logic [NBITS-1:0]     value,
  input  logic                 mode,
  input  logic                 load,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [4*NDIGITS-1:0] bcd,
  output logic [NDIGITS-1:0]   dig_sel,
  output logic [7:0]           SEG
);

  localparam int unsigned BW = 4 * NDIGITS;
  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  logic [NBITS-1:0] mag;
  logic             sign_in;
  logic             ovf_in;
  logic             accept;
  logic             conv_busy;
  logic             conv_done;
  logic             conv_last;
  logic [BW-1:0]    conv_bcd;

  logic             pend_neg_q, pend_ovf_q;
  logic [BW-1:0]    disp_bcd_q;
  logic             disp_neg_q, disp_ovf_q;
  logic [RW-1:0]    ref_cnt_q, ref_cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             ref_wrap;

  logic [3:0]       digit;
  logic             upper_zero;
  logic [6:0]       seg7;

  // Magnitude extraction. In mode 0 the negation is NBITS wide and unsigned, so
  // the most negative input yields 2^(NBITS-1) rather than wrapping.
  always_comb begin
    if (mode) begin
      mag = {1'b0, value[NBITS-2:0]};
    end else if (value[NBITS-1]) begin
      mag = ~value + NBITS'(1);
    end else begin
      mag = value;
    end
    // Negative zero shows as plain 0.
    sign_in = value[NBITS-1] && (mag != '0);
    ovf_in  = 32'(mag) > max_dec(NDIGITS);
  end

  assign accept = load && !conv_busy;

  bin2bcd_seq #(
    .NBITS   (NBITS),
    .NDIGITS (NDIGITS)
  ) u_conv (
    .clk_2 (clk_2),
    .reset (reset),
    .load  (load),
    .mag   (mag),
    .busy  (conv_busy),
    .done  (conv_done),
    .last  (conv_last),
    .bcd   (conv_bcd)
  );

  // Sign and overflow wait in pend_* until the conversion finishes so the
  // display registers change all at once, on the same edge that raises done.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      pend_neg_q <= 1'b0;
      pend_ovf_q <= 1'b0;
      disp_bcd_q <= '0;
      disp_neg_q <= 1'b0;
      disp_ovf_q <= 1'b0;
    end else begin
      if (accept) begin
        pend_neg_q <= sign_in;
        pend_ovf_q <= ovf_in;
      end
      if (conv_last) begin
        disp_bcd_q <= conv_bcd;
        disp_neg_q <= pend_neg_q;
        disp_ovf_q <= pend_ovf_q;
      end
    end
  end

  // Refresh scanning, free-running and independent of the converter.
  always_comb begin
    ref_wrap  = (ref_cnt_q == RW'(REFRESH_DIV - 1));
    ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + RW'(1);
    idx_d     = idx_q;
    if (ref_wrap) begin
      idx_d = (idx_q == IW'(NDIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      ref_cnt_q <= '0;
      idx_q     <= '0;
    end else begin
      ref_cnt_q <= ref_cnt_d;
      idx_q     <= idx_d;
    end
  end

  // Segment generation for the currently selected digit.
  always_comb begin
    digit      = 4'd0;
    upper_zero = 1'b1;
    for (int i = 0; i < int'(NDIGITS); i++) begin
      dig_sel[i] = (idx_q == IW'(i));
      if (idx_q == IW'(i)) begin
        digit = disp_bcd_q[4*i +: 4];
      end
      if ((IW'(i) >= idx_q) && (disp_bcd_q[4*i +: 4] != 4'd0)) begin
        upper_zero = 1'b0;
      end
    end
    if (disp_ovf_q) begin
      seg7 = SEG_DASH[6:0];
    end else if ((idx_q != '0) && upper_zero) begin
      seg7 = SEG_BLANK[6:0];
    end else begin
      seg7 = seg_encode(digit);
    end
    SEG = {disp_neg_q && (idx_q == IW'(NDIGITS - 1)), seg7};
  end

  assign busy     = conv_busy;
  assign done     = conv_done;
  assign overflow = disp_ovf_q;
  assign bcd      = disp_bcd_q;

endmodule

// File: tb/tb_seg_signed_display.sv
// Bench for seg_signed_display: two instances share stimulus (3 digits / refresh 4,
// and 2 digits / refresh 3 so overflow is reachable). Accepted loads push the
// expected number into a scoreboard; a monitor pops it on done and checks every
// output each cycle against an integer-arithmetic model of the display.
module tb_seg_signed_display;

  localparam int NB    = 8;
  localparam int DIV_A = 4;
  localparam int DIV_B = 3;
  localparam logic [6:0] SEG_TBL [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic       clk_2 = 1'b0;
  logic       reset = 1'b0;
  logic       load  = 1'b0;
  logic       mode  = 1'b0;
  logic [7:0] value = 8'h00;

  logic       busy_a, done_a, ovf_a;
  logic [11:0] bcd_a;
  logic [2:0] sel_a;
  logic [7:0] seg_a;
  logic       busy_b, done_b, ovf_b;
  logic [7:0] bcd_b;
  logic [1:0] sel_b;
  logic [7:0] seg_b;

  seg_signed_display #(
    .NBITS       (NB),
    .NDIGITS     (3),
    .REFRESH_DIV (DIV_A)
  ) dut_a (
    .clk_2    (clk_2),
    .reset    (reset),
    .value    (value),
    .mode     (mode),
    .load     (load),
    .busy     (busy_a),
    .done     (done_a),
    .overflow (ovf_a),
    .bcd      (bcd_a),
    .dig_sel  (sel_a),
    .SEG      (seg_a)
  );

  seg_signed_display #(
    .NBITS       (NB),
    .NDIGITS     (2),
    .REFRESH_DIV (DIV_B)
  ) dut_b (
    .clk_2    (clk_2),
    .reset    (reset),
    .value    (value),
    .mode     (mode),
    .load     (load),
    .busy     (busy_b),
    .done     (done_b),
    .overflow (ovf_b),
    .bcd      (bcd_b),
    .dig_sel  (sel_b),
    .SEG      (seg_b)
  );

  always #5 clk_2 = ~clk_2;

  typedef struct {
    int mag;
    bit neg;
    int due;
  } exp_t;

  exp_t sb_q[$];

  function automatic int pow10(int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [7:0] exp_seg(int mag, bit neg, int nd, int k);
    logic [6:0] s;
    if (mag > pow10(nd) - 1) s = 7'h40;
    else if (k > 0 && mag < pow10(k)) s = 7'h00;
    else s = SEG_TBL[(mag / pow10(k)) % 10];
    return {neg && (k == nd - 1), s};
  endfunction

  // Digits beyond nd are lost in the converter, so the BCD shows mag mod 10^nd.
  function automatic logic [31:0] exp_bcd(int mag, int nd);
    logic [31:0] r = '0;
    int v = mag % pow10(nd);
    for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  // Reference model: a conversion occupies NB+1 cycles after the accepting edge;
  // done is expected in the last of them. Refresh index counts clock edges.
  int cyc = 0;
  int m_rem = 0;
  int r_cnt_a = 0, r_idx_a = 0, r_cnt_b = 0, r_idx_b = 0;
  int a_sv, a_mag;
  bit a_neg;

  always @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      m_rem = 0;
      sb_q.delete();
      r_cnt_a = 0; r_idx_a = 0;
      r_cnt_b = 0; r_idx_b = 0;
    end else begin
      cyc++;
      r_cnt_a++;
      if (r_cnt_a == DIV_A) begin r_cnt_a = 0; r_idx_a = (r_idx_a + 1) % 3; end
      r_cnt_b++;
      if (r_cnt_b == DIV_B) begin r_cnt_b = 0; r_idx_b = (r_idx_b + 1) % 2; end
      if (m_rem > 0) begin
        m_rem--;
      end else if (load) begin
        if (!mode) begin
          a_sv  = value[7] ? int'(value) - 256 : int'(value);
          a_neg = a_sv < 0;
          a_mag = a_neg ? -a_sv : a_sv;
        end else begin
          a_neg = value[7];
          a_mag = int'(value[6:0]);
        end
        sb_q.push_back('{mag: a_mag, neg: a_neg && (a_mag != 0), due: cyc + NB});
        m_rem = NB + 1;
      end
    end
  end

  int n_vec = 0, n_miss = 0;
  bit rst_seen = 0, end_req = 0, end_done = 0;
  int d_mag = 0;
  bit d_neg = 0;
  exp_t e;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_2 or posedge reset) begin
    if (reset) begin
      d_mag = 0;
      d_neg = 0;
      if (!rst_seen) begin
        rst_seen = 1;
        #1;
        check("rst_busy_a", busy_a, 0);  check("rst_busy_b", busy_b, 0);
        check("rst_done_a", done_a, 0);  check("rst_done_b", done_b, 0);
        check("rst_ovf_a", ovf_a, 0);    check("rst_ovf_b", ovf_b, 0);
        check("rst_sel_a", sel_a, 1);    check("rst_sel_b", sel_b, 1);
        check("rst_seg_a", seg_a, 8'h3F); check("rst_seg_b", seg_b, 8'h3F);
        check("rst_bcd_a", bcd_a, 0);    check("rst_bcd_b", bcd_b, 0);
      end
    end else begin
      rst_seen = 0;
      if (done_a || done_b) begin
        check("done_has_pending_load", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("done_cycle", cyc, e.due);
          d_mag = e.mag;
          d_neg = e.neg;
        end
      end
      check("busy_a", busy_a, m_rem > 0);
      check("busy_b", busy_b, m_rem > 0);
      check("done_a", done_a, m_rem == 1);
      check("done_b", done_b, m_rem == 1);
      check("sel_a", sel_a, 1 << r_idx_a);
      check("sel_b", sel_b, 1 << r_idx_b);
      check("seg_a", seg_a, exp_seg(d_mag, d_neg, 3, r_idx_a));
      check("seg_b", seg_b, exp_seg(d_mag, d_neg, 2, r_idx_b));
      check("bcd_a", bcd_a, exp_bcd(d_mag, 3));
      check("bcd_b", bcd_b, exp_bcd(d_mag, 2));
      check("ovf_a", ovf_a, d_mag > 999);
      check("ovf_b", ovf_b, d_mag > 99);
      if (end_req && !end_done) begin
        check("scoreboard_drained", sb_q.size(), 0);
        end_done = 1;
      end
    end
  end

  task automatic do_conv(logic [7:0] v, logic m);
    value = v;
    mode  = m;
    load  = 1'b1;
    @(negedge clk_2);
    load = 1'b0;
    repeat (NB + 1) @(negedge clk_2);
  endtask

  initial begin
    #2 reset = 1'b1;
    repeat (2) @(negedge clk_2);
    #2 reset = 1'b0;
    @(negedge clk_2);

    do_conv(8'hF6, 1'b0);   // -10
    do_conv(8'h80, 1'b0);   // -128
    do_conv(8'h80, 1'b1);   // negative zero
    do_conv(8'd100, 1'b0);
    do_conv(8'd99, 1'b0);
    do_conv(8'hFF, 1'b1);   // -127
    do_conv(8'h7F, 1'b0);
    do_conv(8'h00, 1'b0);

    // load held high while the value keeps changing
    load = 1'b1;
    repeat (3 * (NB + 2)) begin
      value = 8'($urandom);
      mode  = 1'($urandom);
      @(negedge clk_2);
    end
    load = 1'b0;
    repeat (NB + 2) @(negedge clk_2);

    // reset while a conversion is running
    do_conv(8'h85, 1'b0);
    value = 8'($urandom);
    load  = 1'b1;
    @(negedge clk_2);
    load = 1'b0;
    repeat (3) @(negedge clk_2);
    #2 reset = 1'b1;
    @(negedge clk_2);
    #2 reset = 1'b0;
    repeat (NB + 4) @(negedge clk_2);

    // random traffic, including loads that land while busy
    repeat (400) begin
      load  = ($urandom_range(2) == 0);
      value = 8'($urandom);
      mode  = 1'($urandom);
      @(negedge clk_2);
    end
    load = 1'b0;
    repeat (NB + 4) @(negedge clk_2);

    end_req = 1;
    repeat (2) @(negedge clk_2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
